// File: rtl/spi_tx.sv
// SPI master transmitter: AXI-Stream words shifted out MSB-first in SPI modes 0..3.
// Optional macro SPI_TX_BURST_EN lets back-to-back words share one chip-select.
module spi_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic                      sclk,
  output logic                      txd,
  output logic                      cs_n,
  input  logic [1:0]                spi_mode,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      busy
);

  localparam int EW = $clog2(2 * DATA_WIDTH) + 1;
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH - 1);
  localparam logic [PRESCALE_WIDTH-1:0] P_ONE = PRESCALE_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

  state_t                    state;
  logic [DATA_WIDTH-1:0]     shreg;
  logic [1:0]                mode_reg;
  logic [PRESCALE_WIDTH-1:0] p_last;
  logic [PRESCALE_WIDTH-1:0] cnt;
  logic [EW-1:0]             edge_cnt;

  logic [PRESCALE_WIDTH-1:0] p_last_in;
  logic                      accept;
  logic                      launch;

  // p_last holds P-1 so that prescale 0 and 1 both give a one-cycle half period
  assign p_last_in = (prescale == '0) ? '0 : prescale - P_ONE;
  assign accept    = s_axis_tvalid && s_axis_tready;
  assign launch    = mode_reg[0] ? !edge_cnt[0]
                                 : (edge_cnt[0] && (edge_cnt != LAST_EDGE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      shreg         <= '0;
      mode_reg      <= '0;
      p_last        <= '0;
      cnt           <= '0;
      edge_cnt      <= '0;
      s_axis_tready <= 1'b0;
      sclk          <= 1'b0;
      txd           <= 1'b1;
      cs_n          <= 1'b1;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sclk          <= spi_mode[1];
          txd           <= 1'b1;
          cs_n          <= 1'b1;
          busy          <= 1'b0;
          s_axis_tready <= 1'b1;
        end
        LEAD: begin
          if (cnt == p_last) begin
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            cnt <= cnt + P_ONE;
          end
        end
        SHIFT: begin
          if (cnt == p_last) begin
            cnt      <= '0;
            sclk     <= !sclk;
            edge_cnt <= edge_cnt + EW'(1);
            if (launch) begin
              txd   <= shreg[DATA_WIDTH-1];
              shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
            end
            if (edge_cnt == LAST_EDGE) begin
              state <= TRAIL;
`ifdef SPI_TX_BURST_EN
              s_axis_tready <= (p_last == '0);
`endif
            end
          end else begin
            cnt <= cnt + P_ONE;
          end
        end
        TRAIL: begin
          if (cnt == p_last) begin
            state         <= IDLE;
            cs_n          <= 1'b1;
            busy          <= 1'b0;
            txd           <= 1'b1;
            sclk          <= mode_reg[1];
            s_axis_tready <= 1'b1;
          end else begin
            cnt <= cnt + P_ONE;
`ifdef SPI_TX_BURST_EN
            s_axis_tready <= ((cnt + P_ONE) == p_last);
`endif
          end
        end
        default: state <= IDLE;
      endcase

      // Accept can only fire in IDLE (or the final TRAIL cycle in burst builds)
      if (accept) begin
        state         <= LEAD;
        cs_n          <= 1'b0;
        busy          <= 1'b1;
        s_axis_tready <= 1'b0;
        mode_reg      <= spi_mode;
        p_last        <= p_last_in;
        cnt           <= '0;
        edge_cnt      <= '0;
        sclk          <= spi_mode[1];
        if (spi_mode[0]) begin
          txd   <= 1'b1;
          shreg <= s_axis_tdata;
        end else begin
          txd   <= s_axis_tdata[DATA_WIDTH-1];
          shreg <= {s_axis_tdata[DATA_WIDTH-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_tx.sv
// Self-checking bench for spi_tx: each frame is decoded like a receiver would,
// by sampling txd on the mode's sampling edge of sclk, and compared to the word sent.
module tb_spi_tx;
  localparam int W  = 8;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          sclk;
  logic          txd;
  logic          cs_n;
  logic [1:0]    spi_mode = 2'd0;
  logic [PW-1:0] prescale = '0;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_count = 0;

  spi_tx #(.DATA_WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .sclk(sclk), .txd(txd), .cs_n(cs_n),
    .spi_mode(spi_mode), .prescale(prescale), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (s_axis_tvalid && s_axis_tready) hs_count <= hs_count + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Send one word and decode the resulting frame. After the handshake the
  // inputs are switched to (hold, nxt, mid_mode) to model held tvalid and
  // mid-frame mode changes. Returns at the first idle cycle after the frame.
  task automatic run_frame(input logic [W-1:0] data, input logic [1:0] mode,
                           input logic [PW-1:0] presc, input logic hold,
                           input logic [W-1:0] nxt, input logic [1:0] mid_mode);
    int p, guard, low, samp, edges;
    logic [W-1:0] rx;
    logic prev_sclk, prev_txd, cpol, samp_level;
    p          = (presc == 0) ? 1 : int'(presc);
    cpol       = mode[1];
    samp_level = (mode == 2'd0 || mode == 2'd3);  // sclk level right after a sampling edge
    s_axis_tdata  = data;
    spi_mode      = mode;
    prescale      = presc;
    s_axis_tvalid = 1'b1;
    guard = 0;
    while (s_axis_tready !== 1'b1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("handshake_wait", 64'(guard < 1000), 64'd1);
    @(posedge clk);
    #1;
    s_axis_tdata  = nxt;
    s_axis_tvalid = hold;
    spi_mode      = mid_mode;
    @(negedge clk);
    check("cs_latency", 64'(cs_n), 64'd0);
    low = 0; samp = 0; edges = 0; rx = '0;
    prev_sclk = cpol;
    prev_txd  = txd;
    while (cs_n === 1'b0 && low < 5000) begin
      check("busy_vs_cs", 64'(busy), 64'd1);
      if (sclk !== prev_sclk) begin
        edges++;
        if (sclk === samp_level) begin
          samp++;
          rx = {rx[W-2:0], txd};
          check("txd_setup", 64'(txd), 64'(prev_txd));
        end
      end
      prev_sclk = sclk;
      prev_txd  = txd;
      low++;
      @(negedge clk);
    end
    check("cs_low_cycles", 64'(low), 64'((2 * W + 2) * p));
    check("rx_word", 64'(rx), 64'(data));
    check("sample_edges", 64'(samp), 64'(W));
    check("total_edges", 64'(edges), 64'(2 * W));
    check("idle_sclk", 64'(sclk), 64'(cpol));
    check("idle_txd", 64'(txd), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_tready", 64'(s_axis_tready), 64'd1);
    $display("[TB] frame data=%02h mode=%0d prescale=%0d cs_low=%0d rx=%02h", data, mode, presc, low, rx);
  endtask

  initial begin
    int hs0;
    logic [W-1:0] d;
    logic [1:0] m;
    logic [PW-1:0] pr;

    // Reset values while rst_n is held low
    repeat (3) @(negedge clk);
    check("rst_cs_n", 64'(cs_n), 64'd1);
    check("rst_sclk", 64'(sclk), 64'd0);
    check("rst_txd", 64'(txd), 64'd1);
    check("rst_tready", 64'(s_axis_tready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Mode 0, prescale 2, then modes 1..3 at prescale 3
    run_frame(8'hA5, 2'd0, 16'd2, 1'b0, 8'h00, 2'd0);
    run_frame(8'h3C, 2'd1, 16'd3, 1'b0, 8'h00, 2'd1);
    run_frame(8'h3C, 2'd2, 16'd3, 1'b0, 8'h00, 2'd2);
    run_frame(8'h3C, 2'd3, 16'd3, 1'b0, 8'h00, 2'd3);

    // Prescale 0 behaves like 1
    run_frame(8'hFF, 2'd0, 16'd0, 1'b0, 8'h00, 2'd0);

    // tvalid held across three words
    hs0 = hs_count;
    run_frame(8'h01, 2'd0, 16'd2, 1'b1, 8'h80, 2'd0);
    run_frame(8'h80, 2'd0, 16'd2, 1'b1, 8'h55, 2'd0);
    run_frame(8'h55, 2'd0, 16'd2, 1'b0, 8'h00, 2'd0);
    check("held_handshakes", 64'(hs_count - hs0), 64'd3);

    // Mode changed mid-frame: frame completes in mode 0, next frame uses mode 3
    run_frame(8'hC3, 2'd0, 16'd2, 1'b0, 8'h00, 2'd3);
    run_frame(8'h96, 2'd3, 16'd2, 1'b0, 8'h00, 2'd3);

    // Reset mid-SHIFT around bit 4
    s_axis_tdata = 8'h96; spi_mode = 2'd0; prescale = 16'd2; s_axis_tvalid = 1'b1;
    begin
      int g;
      g = 0;
      while (s_axis_tready !== 1'b1 && g < 1000) begin @(negedge clk); g++; end
    end
    @(posedge clk);
    #1 s_axis_tvalid = 1'b0;
    repeat (18) @(negedge clk);
    check("pre_reset_cs", 64'(cs_n), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_cs_n", 64'(cs_n), 64'd1);
    check("abort_sclk", 64'(sclk), 64'd0);
    check("abort_txd", 64'(txd), 64'd1);
    check("abort_tready", 64'(s_axis_tready), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(8'h5A, 2'd0, 16'd2, 1'b0, 8'h00, 2'd0);

    // Randomized frames
    for (int i = 0; i < 6; i++) begin
      d  = W'($urandom);
      m  = 2'($urandom_range(0, 3));
      pr = PW'($urandom_range(0, 4));
      run_frame(d, m, pr, 1'b0, 8'h00, m);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/spi_tx.md
Name: spi_tx

Overview:
SPI master-side transmitter. It accepts words on an AXI-Stream slave, generates sclk, cs_n and txd, and shifts each word out MSB-first in the selected SPI mode. Its sclk/txd outputs pair directly with the spi_rx receive block: txd is always stable at spi_rx's sampling edge. It sits between a packetiser/CPU-side stream and the SPI pins.

Parameters:
DATA_WIDTH, 8, word width in bits; legal range 2..64.
PRESCALE_WIDTH, 16, width of the prescale configuration input.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
s_axis_tdata  input  DATA_WIDTH  word to transmit
s_axis_tvalid  input  1  word valid
s_axis_tready  output  1  block ready to accept a word
sclk  output  1  SPI serial clock
txd  output  1  serial data out, MSB first
cs_n  output  1  chip select, active low
spi_mode  input  2  SPI mode 0..3; bit 1 = CPOL (idle sclk level)
prescale  input  PRESCALE_WIDTH  sclk half-period in clk cycles; 0 is treated as 1
busy  output  1  frame in progress

Behaviour:
- Reset: asynchronous, active-low; all registers are forced immediately, including mid-frame. While asserted: cs_n=1, sclk=0, txd=1, s_axis_tready=0, busy=0, state=IDLE. An aborted frame is discarded.
- Let P be the latched prescale (0 maps to 1). spi_mode and prescale are latched on the accepting handshake; changes mid-frame are ignored.
- Launch-first modes are 1 and 3 (spi_mode[0]=1). Sample-first modes are 0 and 2. Sampling edge is rising for modes 0/3 and falling for modes 1/2, which matches spi_rx.
- FSM:
  - IDLE: s_axis_tready=1, cs_n=1, busy=0, txd=1, sclk registered to spi_mode[1] each cycle. On tvalid&&tready, latch data/mode/P and go to LEAD next cycle.
  - LEAD: cs_n=0, busy=1. In sample-first modes, txd=MSB from the first LEAD cycle; in launch-first modes, txd holds 1. Hold P cycles, then go to SHIFT.
  - SHIFT: sclk toggles after every P cycles, for exactly 2*DATA_WIDTH edges (edge counter 0..2*DATA_WIDTH-1). Launch edges are even-indexed in launch-first modes and odd-indexed in sample-first modes; the bit change coincides with the edge. In sample-first modes, edge 2*DATA_WIDTH-1 does not launch. DATA_WIDTH bits are launched in total. After the last edge, sclk equals CPOL; go to TRAIL.
  - TRAIL: sclk=CPOL, cs_n=0, txd holds the LSB. Hold P cycles, then go to IDLE: cs_n=1, txd=1, tready=1.
- Latency: cs_n falls 1 cycle after the handshake. cs_n is low for exactly (2*DATA_WIDTH+2)*P cycles. busy equals !cs_n. Minimum gap between frames is 1 IDLE cycle (cs_n high at least 1 cycle).
- s_axis_tready is low in every non-IDLE state; tvalid held during a frame is not consumed until IDLE.
- tvalid rising in the same cycle as a reset release is ignored; the first handshake is possible from the first post-reset IDLE cycle.
- Bit counter must not overflow for DATA_WIDTH=64: edge counter width is clog2(2*DATA_WIDTH)+1.

Optional Feature:
SPI_TX_BURST_EN
- Defined: in the last TRAIL cycle, s_axis_tready=1. If tvalid is high, the new word is latched and the FSM goes straight to LEAD with cs_n held low, so back-to-back words share one chip-select. If tvalid is low, the FSM goes to IDLE normally.
- Undefined: every word is framed by its own cs_n assertion, with at least 1 IDLE cycle between frames.

Test Plan:
- Mode 0, DATA_WIDTH=8, prescale=2, tdata=0xA5, looped back into spi_rx -> cs_n low 36 cycles, 8 rising sclk edges, spi_rx outputs 0xA5, busy high exactly while cs_n low.
- Modes 1, 2, 3 each with tdata=0x3C, prescale=3 -> sclk idles at CPOL, txd never changes within 1 cycle of a sampling edge, spi_rx receives 0x3C in every mode.
- prescale=0, tdata=0xFF -> behaves identically to prescale=1: 18 cycles of cs_n low.
- tvalid held high with 3 words (0x01, 0x80, 0x55) -> 3 handshakes; cs_n deasserts ≥1 cycle between frames (burst undefined), or stays low for 54*P contiguous cycles (burst defined).
- rst_n pulsed low during SHIFT bit 4 -> same-cycle cs_n=1, sclk=0, txd=1, tready=0; after release, the next word 0x5A transmits correctly.
- spi_mode changed from 0 to 3 mid-frame -> current frame completes in mode 0; the next frame uses mode 3.
